// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host transmitter state encoding, frame length and
// the command/response bytes exchanged with the keyboard.
package ps2_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQ,
        S_SEND,
        S_ACK,
        S_WAIT_IDLE,
        S_FAIL
    } ps2_tx_state_e;

    // Device clock falls per host-to-device frame: 8 data, parity, stop, ACK.
    localparam int FRAME_FALLS = 11;

    localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
    localparam logic [7:0] PS2_RSP_ACK      = 8'hFA;

    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// PS/2 line conditioning: 2-FF synchronizers for both lines, a stability
// filter on the clock and a one-cycle strobe on each accepted clock fall.
module ps2_line_filter #(
    parameter int FILTER_CYCLES = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clk_pin,
    input  logic data_pin,
    output logic clk_filt,
    output logic clk_fall,
    output logic data_sync
);

    localparam int CW = $clog2(FILTER_CYCLES + 1);

    logic          clk_meta;
    logic          clk_sync;
    logic          data_meta;
    logic [CW-1:0] stable_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            clk_meta   <= 1'b1;
            clk_sync   <= 1'b1;
            data_meta  <= 1'b1;
            data_sync  <= 1'b1;
            clk_filt   <= 1'b1;
            clk_fall   <= 1'b0;
            stable_cnt <= '0;
        end else begin
            clk_meta  <= clk_pin;
            clk_sync  <= clk_meta;
            data_meta <= data_pin;
            data_sync <= data_meta;
            clk_fall  <= 1'b0;
            // A new level is taken only after FILTER_CYCLES consecutive samples
            // disagree with the current filtered value.
            if (clk_sync == clk_filt) begin
                stable_cnt <= '0;
            end else if (stable_cnt == CW'(FILTER_CYCLES - 1)) begin
                clk_filt   <= clk_sync;
                clk_fall   <= ~clk_sync;
                stable_cnt <= '0;
            end else begin
                stable_cnt <= stable_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: request-to-send, 8 data bits, odd parity,
// stop and device ACK over the shared open-drain clock/data pair.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 12000,
    parameter int TIMEOUT_CYCLES = 2000000,
    parameter int FILTER_CYCLES  = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       done,
    output logic       err,
    inout  wire        PS2_CLK,
    inout  wire        PS2_DATA
);

    localparam int IW = $clog2(INHIBIT_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    ps2_tx_state_e state;
    logic          clk_low;
    logic          data_low;
    logic [9:0]    shift;
    logic [3:0]    bit_cnt;
    logic [IW-1:0] inh_cnt;
    logic [TW-1:0] to_cnt;
    logic          clk_filt;
    logic          clk_fall;
    logic          data_sync;
    logic          to_expired;

    assign PS2_CLK  = clk_low  ? 1'b0 : 1'bz;
    assign PS2_DATA = data_low ? 1'b0 : 1'bz;

    ps2_line_filter #(
        .FILTER_CYCLES(FILTER_CYCLES)
    ) u_filter (
        .clk      (clk),
        .rst      (rst),
        .clk_pin  (PS2_CLK),
        .data_pin (PS2_DATA),
        .clk_filt (clk_filt),
        .clk_fall (clk_fall),
        .data_sync(data_sync)
    );

    // The FAIL state adds one cycle before err, so the wait is cut two short
    // to put err exactly TIMEOUT_CYCLES after the last clear.
    assign to_expired = (to_cnt == TW'(TIMEOUT_CYCLES - 2));

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= S_IDLE;
            clk_low  <= 1'b0;
            data_low <= 1'b0;
            tx_ready <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            bit_cnt  <= '0;
            inh_cnt  <= '0;
            to_cnt   <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    clk_low  <= 1'b0;
                    data_low <= 1'b0;
                    busy     <= 1'b0;
                    tx_ready <= 1'b1;
                    if (tx_valid && tx_ready) begin
                        shift    <= {1'b1, odd_parity(tx_data), tx_data};
                        state    <= S_INHIBIT;
                        tx_ready <= 1'b0;
                        busy     <= 1'b1;
                        clk_low  <= 1'b1;
                        inh_cnt  <= '0;
                    end
                end
                S_INHIBIT: begin
                    if (inh_cnt == IW'(INHIBIT_CYCLES - 1)) begin
                        state    <= S_REQ;
                        data_low <= 1'b1;
                    end else begin
                        inh_cnt <= inh_cnt + 1'b1;
                    end
                end
                S_REQ: begin
                    clk_low <= 1'b0;
                    state   <= S_SEND;
                    to_cnt  <= '0;
                    bit_cnt <= '0;
                end
                S_SEND: begin
                    // Each device fall presents the next LSB; the stop bit is a release.
                    if (clk_fall) begin
                        to_cnt   <= '0;
                        data_low <= ~shift[0];
                        shift    <= {1'b0, shift[9:1]};
                        bit_cnt  <= bit_cnt + 1'b1;
                        if (bit_cnt == 4'(FRAME_FALLS - 2)) begin
                            state <= S_ACK;
                        end
                    end else if (to_expired) begin
                        state    <= S_FAIL;
                        data_low <= 1'b0;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                S_ACK: begin
                    if (clk_fall) begin
                        to_cnt <= '0;
                        state  <= data_sync ? S_FAIL : S_WAIT_IDLE;
                    end else if (to_expired) begin
                        state <= S_FAIL;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                S_WAIT_IDLE: begin
                    if (data_sync && clk_filt) begin
                        done  <= 1'b1;
                        state <= S_IDLE;
                    end else if (to_expired) begin
                        state <= S_FAIL;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                S_FAIL: begin
                    clk_low  <= 1'b0;
                    data_low <= 1'b0;
                    err      <= 1'b1;
                    state    <= S_IDLE;
                end
                default: begin
                    clk_low  <= 1'b0;
                    data_low <= 1'b0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule
